md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
- Multiply/divide controller for the P6 five-stage MIPS pipeline.
- Owns HI/LO and sequences a multi-cycle mult/multu/div/divu operation launched from E.
- Supplies md_out for mfhi/mflo, which travels E→M→W as the mdOut field of the pipeline registers.
- Raises stall_md toward the hazard logic while the unit is in use, so D holds any MD instruction.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu.
- DIV_LAT, 10, busy cycles for div/divu.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- en_E  in  1  E-stage instruction valid (low on bubble/flush)
- md_op_E  in  4  MD opcode of the E instruction (md_pkg encoding)
- md_op_D  in  4  MD opcode of the D instruction (stall detection)
- rs_E  in  32  forwarded rs value in E
- rt_E  in  32  forwarded rt value in E
- start  out  1  launch pulse, combinational
- busy  out  1  operation in progress, registered
- stall_md  out  1  stall request to the D/E hazard logic
- md_out  out  32  HI for mfhi, LO for mflo, else 0; combinational from md_op_E
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset (synchronous, active-high; clock clk): busy=0, cnt=0, hi=lo=0, latched operands=0, state IDLE. Reset mid-operation aborts the operation with no HI/LO write.
- start = en_E & md_op_E∈{MULT,MULTU,DIV,DIVU} & ~busy.
- stall_md = (md_op_D≠NONE) & (start | busy). Covers every MD op in D, including mfhi/mflo/mthi/mtlo.
- States:
  - IDLE: on start at edge t, go to BUSY; latch rs_E/rt_E/op; cnt←LAT (MULT_LAT or DIV_LAT); busy←1.
  - BUSY: each edge cnt←cnt−1. On the edge where cnt==1, write hi/lo, set busy←0, return to IDLE.
- Timing: busy is high for exactly LAT cycles after start. New HI/LO are visible on hi/lo from cycle t+LAT+1. A following mfhi reaches E no earlier than that cycle.
- mthi/mtlo: when en_E and not busy, write rs_E into hi/lo at the next edge. While busy they are ignored; stall_md guarantees this never happens.
- Result rules:
  - mult: signed 64-bit product; hi=[63:32], lo=[31:0].
  - multu: unsigned 64-bit product; same hi/lo split.
  - div: lo=quotient truncated toward zero; hi=remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
  - 0x80000000 div 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero: full DIV_LAT busy, then hi/lo unchanged.
- Back-to-back start cannot occur: the second MD op is held in D by stall_md.
- start while en_E=0 never occurs.
- md_out is independent of busy. Correctness relies on the stall.

Decomposition:
- md_pkg: opcode constants NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8; state encoding IDLE/BUSY; default latencies.
- Sub-module md_arith: purely combinational. Inputs: latched op and operands. Outputs: 64-bit {hi,lo} result plus a div-by-zero flag.
- md_ctrl holds the counter, FSM, HI/LO registers and the stall logic.

Test Plan:
- mult, rs=0xFFFFFFFE (−2), rt=3 → start=1 for one cycle; busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu, rs=7, rt=2 → busy 10 cycles, then hi=1, lo=3. div with rs=−7, rt=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFD.
- mult in E with mflo in D → stall_md high in the start cycle and all 5 busy cycles, low afterwards. mflo then returns md_out=lo.
- div, rt=0, with prior hi=0x11, lo=0x22 → busy 10 cycles; hi/lo remain 0x11/0x22.
- Reset asserted at busy cycle 3 of a div → next cycle busy=0, hi=lo=0, no later write.
- mthi rs=0xDEADBEEF then mtlo rs=0x1234 → hi=0xDEADBEEF and lo=0x1234 one edge after each. mfhi then gives md_out=0xDEADBEEF with no stall.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encoding, FSM states
// and default latencies.
package md_pkg;

  typedef logic [3:0] md_op_t;

  localparam md_op_t MD_NONE  = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MTHI  = 4'd5;
  localparam md_op_t MD_MTLO  = 4'd6;
  localparam md_op_t MD_MFHI  = 4'd7;
  localparam md_op_t MD_MFLO  = 4'd8;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_arith(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath working on the latched op and operands.
// Produces the {hi,lo} result and flags division by zero.
module md_arith
  import md_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0] q_mag, r_mag;
  logic [63:0] a_sx, b_sx;

  // Signed division goes through magnitudes so that INT_MIN / -1 wraps to
  // INT_MIN with remainder 0 instead of depending on tool overflow behaviour.
  assign a_mag      = a[31] ? (32'd0 - a) : a;
  assign b_mag      = b[31] ? (32'd0 - b) : b;
  assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;
  assign a_sx       = {{32{a[31]}}, a};
  assign b_sx       = {{32{b[31]}}, b};

  // Select the result for the latched op.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and infers a latch.
    result   = 64'd0;
    div_zero = 1'b0;
    case (op)
      MD_MULT:  result = a_sx * b_sx;
      MD_MULTU: result = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        div_zero = (b == 32'd0);
        result[31:0]  = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
        result[63:32] = a[31] ? (32'd0 - r_mag) : r_mag;
      end
      MD_DIVU: begin
        div_zero = (b == 32'd0);
        result   = {a % b_safe, a / b_safe};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences a multi-cycle op launched
// from E, serves mfhi/mflo and stalls D while the unit is in use.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_E,
  input  logic [3:0]  md_op_E,
  input  logic [3:0]  md_op_D,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_t           op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [63:0]      result;
  logic             div_zero;

  md_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (result),
    .div_zero (div_zero)
  );

  assign busy     = (state_q == BUSY);
  assign start    = en_E & is_arith(md_op_E) & ~busy;
  assign stall_md = (md_op_D != MD_NONE) & (start | busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

  // mfhi/mflo read the architectural registers directly; the stall keeps
  // them from reaching E while an operation is still in flight.
  always_comb begin
    md_out = 32'd0;
    if (md_op_E == MD_MFHI)      md_out = hi_q;
    else if (md_op_E == MD_MFLO) md_out = lo_q;
  end

  // Next-state: launch, count down, commit the result, or handle mthi/mtlo.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          op_d    = md_op_E;
          a_d     = rs_E;
          b_d     = rt_E;
          cnt_d   = is_mult(md_op_E) ? MULT_CNT : DIV_CNT;
        end else if (en_E && (md_op_E == MD_MTHI)) begin
          hi_d = rs_E;
        end else if (en_E && (md_op_E == MD_MTLO)) begin
          lo_d = rs_E;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          // Division by zero still takes the full latency but leaves HI/LO alone.
          if (!div_zero) begin
            hi_d = result[63:32];
            lo_d = result[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and architectural registers; reset aborts any op without a write.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios plus random legal
// instruction streams compared against a cycle-level behavioural model.
module tb_md_ctrl;

  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3,
                         DIVU = 4'd4, MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7,
                         MFLO = 4'd8;

  logic        clk, reset, en_E;
  logic [3:0]  md_op_E, md_op_D;
  logic [31:0] rs_E, rt_E;
  logic        start, busy, stall_md;
  logic [31:0] md_out, hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
  logic        m_wr;
  int          m_left;

  // last values observed by step()
  logic        obs_start, obs_stall;
  logic [31:0] obs_md_out;

  md_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .en_E     (en_E),
    .md_op_E  (md_op_E),
    .md_op_D  (md_op_D),
    .rs_E     (rs_E),
    .rt_E     (rt_E),
    .start    (start),
    .busy     (busy),
    .stall_md (stall_md),
    .md_out   (md_out),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic arith_op(input logic [3:0] op);
    return op inside {MULT, MULTU, DIV, DIVU};
  endfunction

  // Architectural result of an op, straight from the instruction semantics.
  task automatic compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic wr, output logic [31:0] rhi, output logic [31:0] rlo);
    int sa, sb;
    longint p;
    logic [63:0] up;
    sa = a;
    sb = b;
    wr = 1'b1;
    rhi = 32'd0;
    rlo = 32'd0;
    case (op)
      MULT: begin
        p = longint'(sa) * longint'(sb);
        rhi = p[63:32];
        rlo = p[31:0];
      end
      MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        rhi = up[63:32];
        rlo = up[31:0];
      end
      DIV: begin
        if (b == 32'd0) wr = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rlo = 32'h8000_0000;
          rhi = 32'd0;
        end else begin
          rlo = sa / sb;
          rhi = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          rlo = a / b;
          rhi = a % b;
        end
      end
    endcase
  endtask

  // Drive one cycle, compare every output with the model, then clock both.
  task automatic step(input logic rst, input logic en, input logic [3:0] ope,
                      input logic [3:0] opd, input logic [31:0] a, input logic [31:0] b);
    logic e_busy, e_start, e_stall;
    logic [31:0] e_md;
    reset = rst; en_E = en; md_op_E = ope; md_op_D = opd; rs_E = a; rt_E = b;
    #1;
    e_busy  = (m_left > 0);
    e_start = en && arith_op(ope) && !e_busy;
    e_stall = (opd != NONE) && (e_start || e_busy);
    e_md    = (ope == MFHI) ? m_hi : (ope == MFLO) ? m_lo : 32'd0;
    check("start", start, e_start);
    check("busy", busy, e_busy);
    check("stall_md", stall_md, e_stall);
    check("md_out", md_out, e_md);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    obs_start = start; obs_stall = stall_md; obs_md_out = md_out;
    @(posedge clk);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin
        m_hi = m_rhi;
        m_lo = m_rlo;
      end
    end else if (e_start) begin
      m_left = (ope == MULT || ope == MULTU) ? 5 : 10;
      compute(ope, a, b, m_wr, m_rhi, m_rlo);
    end else if (en && ope == MTHI) m_hi = a;
    else if (en && ope == MTLO) m_lo = a;
    #1;
  endtask

  // Idle E until the unit frees up; returns the number of busy cycles seen.
  task automatic drain(input logic [3:0] opd, output int nb);
    nb = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      nb++;
      step(1'b0, 1'b1, NONE, opd, 32'd0, 32'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    reset = 1'b1; en_E = 1'b0; md_op_E = NONE; md_op_D = NONE; rs_E = 0; rt_E = 0;
    m_hi = 0; m_lo = 0; m_left = 0; m_wr = 0; m_rhi = 0; m_rlo = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // mult -2 * 3 with mflo waiting in D
    step(1'b0, 1'b1, MULT, MFLO, 32'hFFFF_FFFE, 32'd3);
    check("mult_start", obs_start, 1'b1);
    check("mult_stall0", obs_stall, 1'b1);
    drain(MFLO, nb);
    check("mult_busy_cycles", nb, 5);
    step(1'b0, 1'b1, MFLO, MFLO, 32'd0, 32'd0);
    check("mflo_value", obs_md_out, 32'hFFFF_FFFA);
    check("mflo_no_stall", obs_stall, 1'b0);
    check("mult_hi", hi, 32'hFFFF_FFFF);

    // divu 7 / 2
    step(1'b0, 1'b1, DIVU, NONE, 32'd7, 32'd2);
    drain(NONE, nb);
    check("divu_busy_cycles", nb, 10);
    check("divu_hi", hi, 32'd1);
    check("divu_lo", lo, 32'd3);

    // div -7 / 2
    step(1'b0, 1'b1, DIV, NONE, 32'hFFFF_FFF9, 32'd2);
    drain(NONE, nb);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    // div by zero keeps prior HI/LO
    step(1'b0, 1'b1, MTHI, NONE, 32'h11, 32'd0);
    step(1'b0, 1'b1, MTLO, NONE, 32'h22, 32'd0);
    step(1'b0, 1'b1, DIV, NONE, 32'd99, 32'd0);
    drain(NONE, nb);
    check("div0_busy_cycles", nb, 10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    // INT_MIN / -1
    step(1'b0, 1'b1, DIV, NONE, 32'h8000_0000, 32'hFFFF_FFFF);
    drain(NONE, nb);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // reset during the third busy cycle of a div
    step(1'b0, 1'b1, DIV, NONE, 32'd100, 32'd7);
    step(1'b0, 1'b1, NONE, NONE, 32'd0, 32'd0);
    step(1'b0, 1'b1, NONE, NONE, 32'd0, 32'd0);
    step(1'b1, 1'b1, NONE, NONE, 32'd0, 32'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (12) step(1'b0, 1'b1, NONE, NONE, 32'd0, 32'd0);
    check("abort_hi_late", hi, 32'd0);
    check("abort_lo_late", lo, 32'd0);

    // mthi / mtlo / mfhi
    step(1'b0, 1'b1, MTHI, NONE, 32'hDEAD_BEEF, 32'd0);
    check("mthi", hi, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, MTLO, NONE, 32'h1234, 32'd0);
    check("mtlo", lo, 32'h1234);
    step(1'b0, 1'b1, MFHI, MFHI, 32'd0, 32'd0);
    check("mfhi_value", obs_md_out, 32'hDEAD_BEEF);
    check("mfhi_no_stall", obs_stall, 1'b0);

    // random legal instruction streams: nothing MD enters E while busy
    for (int i = 0; i < 600; i++) begin
      if (m_left > 0)
        step(1'b0, 1'($urandom_range(0, 1)), NONE, 4'($urandom_range(0, 8)), pick(), pick());
      else
        step(1'b0, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 8)),
             4'($urandom_range(0, 8)), pick(), pick());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
